// File: rtl/thread_registers_if.sv
// Operand/writeback bundle between a thread's decode/control logic and its register file.
// The control side owns everything except the registered rs/rt operands.
interface thread_registers_if #(
   parameter int DATA_BITS = 8
);
   logic                 enable;
   logic [7:0]           block_id;
   logic [2:0]           core_state;
   logic [3:0]           decoded_rd_address;
   logic [3:0]           decoded_rs_address;
   logic [3:0]           decoded_rt_address;
   logic                 decoded_reg_write_enable;
   logic [1:0]           decoded_reg_input_mux;
   logic [DATA_BITS-1:0] decoded_immediate;
   logic [DATA_BITS-1:0] alu_out;
   logic [DATA_BITS-1:0] lsu_out;
   logic [DATA_BITS-1:0] rs;
   logic [DATA_BITS-1:0] rt;

   modport master (
      output enable, block_id, core_state,
      output decoded_rd_address, decoded_rs_address, decoded_rt_address,
      output decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
      output alu_out, lsu_out,
      input  rs, rt
   );

   modport slave (
      input  enable, block_id, core_state,
      input  decoded_rd_address, decoded_rs_address, decoded_rt_address,
      input  decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
      input  alu_out, lsu_out,
      output rs, rt
   );
endinterface

// File: rtl/thread_registers.sv
// Per-thread 16-entry register file: reads in REQUEST, writes in UPDATE.
// R13..R15 are read-only identity registers (block ID, block size, thread ID).
module thread_registers #(
   parameter int THREADS_PER_BLOCK = 4,
   parameter int THREAD_ID         = 0,
   parameter int DATA_BITS         = 8
) (
   input logic               clk,
   input logic               reset,
   thread_registers_if.slave bus
);
   localparam logic [2:0] ST_REQUEST = 3'b011;
   localparam logic [2:0] ST_UPDATE  = 3'b110;

   localparam logic [1:0] MUX_ALU   = 2'b00;
   localparam logic [1:0] MUX_LSU   = 2'b01;
   localparam logic [1:0] MUX_CONST = 2'b10;

   logic [DATA_BITS-1:0] r_regs [16];
   logic [DATA_BITS-1:0] r_rs;
   logic [DATA_BITS-1:0] r_rt;

   logic                 w_rd_en;
   logic                 w_wr_en;
   logic [DATA_BITS-1:0] w_wr_data;

   assign w_rd_en = bus.enable && (bus.core_state == ST_REQUEST);

   // Mux 11 means "no write"; R13..R15 are excluded by the address bound.
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_data = '0;
      if (bus.enable && (bus.core_state == ST_UPDATE) &&
          bus.decoded_reg_write_enable && (bus.decoded_rd_address <= 4'd12)) begin
         case (bus.decoded_reg_input_mux)
            MUX_ALU:   begin w_wr_en = 1'b1; w_wr_data = bus.alu_out;           end
            MUX_LSU:   begin w_wr_en = 1'b1; w_wr_data = bus.lsu_out;           end
            MUX_CONST: begin w_wr_en = 1'b1; w_wr_data = bus.decoded_immediate; end
            default:   begin w_wr_en = 1'b0; w_wr_data = '0;                    end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 13; i++) begin
            r_regs[i] <= '0;
         end
         r_regs[13] <= '0;
         r_regs[14] <= DATA_BITS'(THREADS_PER_BLOCK);
         r_regs[15] <= DATA_BITS'(THREAD_ID);
         r_rs       <= '0;
         r_rt       <= '0;
      end else begin
         // R13 follows block_id regardless of enable/state, so a same-edge read sees the old value.
         r_regs[13] <= DATA_BITS'(bus.block_id);
         if (w_wr_en) begin
            r_regs[bus.decoded_rd_address] <= w_wr_data;
         end
         if (w_rd_en) begin
            r_rs <= r_regs[bus.decoded_rs_address];
            r_rt <= r_regs[bus.decoded_rt_address];
         end
      end
   end

   assign bus.rs = r_rs;
   assign bus.rt = r_rt;
endmodule

// File: tb/tb_thread_registers.sv
// Directed bench for thread_registers (THREAD_ID=3, THREADS_PER_BLOCK=4).
module tb_thread_registers;
   localparam logic [2:0] IDLE    = 3'b000;
   localparam logic [2:0] WAIT    = 3'b100;
   localparam logic [2:0] REQUEST = 3'b011;
   localparam logic [2:0] EXECUTE = 3'b101;
   localparam logic [2:0] UPDATE  = 3'b110;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   thread_registers_if #(.DATA_BITS(8)) bus ();

   thread_registers #(
      .THREADS_PER_BLOCK (4),
      .THREAD_ID         (3),
      .DATA_BITS         (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic [2:0] st);
      bus.core_state = st;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] rd, input logic [1:0] mux, input logic [7:0] imm,
                     input logic [7:0] alu, input logic [7:0] lsu, input logic [2:0] st);
      bus.decoded_reg_write_enable = 1'b1;
      bus.decoded_rd_address       = rd;
      bus.decoded_reg_input_mux    = mux;
      bus.decoded_immediate        = imm;
      bus.alu_out                  = alu;
      bus.lsu_out                  = lsu;
      step(st);
      bus.decoded_reg_write_enable = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] st);
      bus.decoded_rs_address = a;
      bus.decoded_rt_address = b;
      step(st);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      bus.enable = 1'b1;
      bus.block_id = 8'd7;
      bus.core_state = IDLE;
      bus.decoded_rd_address = 4'd0;
      bus.decoded_rs_address = 4'd0;
      bus.decoded_rt_address = 4'd0;
      bus.decoded_reg_write_enable = 1'b0;
      bus.decoded_reg_input_mux = 2'b11;
      bus.decoded_immediate = 8'h00;
      bus.alu_out = 8'h00;
      bus.lsu_out = 8'h00;
      step(IDLE);
      step(IDLE);
      check("reset_rs", bus.rs, 8'h00);
      check("reset_rt", bus.rt, 8'h00);
      reset = 1'b0;

      // identity registers
      rd(4'd14, 4'd15, REQUEST);
      check("id_r14", bus.rs, 8'd4);
      check("id_r15", bus.rt, 8'd3);
      rd(4'd13, 4'd0, REQUEST);
      check("id_r13", bus.rs, 8'd7);
      check("id_r0", bus.rt, 8'd0);

      // CONST then ALU writeback
      wr(4'd1, 2'b10, 8'h25, 8'h00, 8'h00, UPDATE);
      wr(4'd2, 2'b10, 8'h10, 8'h00, 8'h00, UPDATE);
      rd(4'd1, 4'd2, REQUEST);
      check("const_r1", bus.rs, 8'h25);
      check("const_r2", bus.rt, 8'h10);
      wr(4'd3, 2'b00, 8'h00, 8'h35, 8'h00, UPDATE);
      rd(4'd3, 4'd3, REQUEST);
      check("alu_r3_rs", bus.rs, 8'h35);
      check("alu_r3_rt", bus.rt, 8'h35);

      // LSU writeback, then mux 11 must not write
      wr(4'd5, 2'b01, 8'h00, 8'h00, 8'hAB, UPDATE);
      wr(4'd5, 2'b11, 8'h00, 8'h00, 8'h00, UPDATE);
      rd(4'd5, 4'd1, REQUEST);
      check("lsu_r5", bus.rs, 8'hAB);
      check("lsu_r1", bus.rt, 8'h25);

      // read-only identity registers
      wr(4'd13, 2'b10, 8'hFF, 8'hFF, 8'hFF, UPDATE);
      wr(4'd14, 2'b10, 8'hFF, 8'hFF, 8'hFF, UPDATE);
      wr(4'd15, 2'b10, 8'hFF, 8'hFF, 8'hFF, UPDATE);
      rd(4'd13, 4'd14, REQUEST);
      check("ro_r13", bus.rs, 8'd7);
      check("ro_r14", bus.rt, 8'd4);
      rd(4'd15, 4'd12, REQUEST);
      check("ro_r15", bus.rs, 8'd3);
      check("ro_r12", bus.rt, 8'd0);
      rd(4'd0, 4'd2, REQUEST);
      check("ro_r0", bus.rs, 8'd0);
      check("ro_r2", bus.rt, 8'h10);

      // gating: wrong state, enable low
      wr(4'd6, 2'b10, 8'h77, 8'h00, 8'h00, EXECUTE);
      bus.enable = 1'b0;
      wr(4'd6, 2'b10, 8'h66, 8'h00, 8'h00, UPDATE);
      bus.enable = 1'b1;
      rd(4'd6, 4'd5, REQUEST);
      check("gate_r6", bus.rs, 8'h00);
      check("gate_r5", bus.rt, 8'hAB);
      bus.enable = 1'b0;
      rd(4'd1, 4'd2, REQUEST);
      check("dis_hold_rs", bus.rs, 8'h00);
      check("dis_hold_rt", bus.rt, 8'hAB);
      bus.enable = 1'b1;
      rd(4'd1, 4'd2, WAIT);
      check("wait_hold_rs", bus.rs, 8'h00);
      check("wait_hold_rt", bus.rt, 8'hAB);

      // block_id change: same-edge read returns old R13
      bus.block_id = 8'd9;
      rd(4'd13, 4'd13, REQUEST);
      check("bid_old", bus.rs, 8'd7);
      rd(4'd13, 4'd1, REQUEST);
      check("bid_new", bus.rs, 8'd9);
      check("bid_r1", bus.rt, 8'h25);

      // reset coincident with an UPDATE write
      wr(4'd4, 2'b10, 8'h5A, 8'h00, 8'h00, UPDATE);
      rd(4'd4, 4'd4, REQUEST);
      check("pre_rst_r4", bus.rs, 8'h5A);
      reset = 1'b1;
      wr(4'd4, 2'b10, 8'h11, 8'h00, 8'h00, UPDATE);
      check("rst_rs", bus.rs, 8'h00);
      check("rst_rt", bus.rt, 8'h00);
      reset = 1'b0;
      rd(4'd4, 4'd14, REQUEST);
      check("rst_r4", bus.rs, 8'h00);
      check("rst_r14", bus.rt, 8'd4);
      rd(4'd15, 4'd13, REQUEST);
      check("rst_r15", bus.rs, 8'd3);
      check("rst_r13", bus.rt, 8'd9);
      rd(4'd1, 4'd5, REQUEST);
      check("rst_r1", bus.rs, 8'h00);
      check("rst_r5", bus.rt, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
